paddle_ctrl: RTL and testbench
==============================

// Module: paddle_ctrl
// PURPOSE
//  Next-generation paddle engine for the pong datapath. It holds one paddle's
//  vertical position and moves it once per video frame, with hold-to-accelerate
//  speed ramping and clamping to the screen edges. It publishes the paddle
//  bounding box to the ball/collision logic and a registered draw strobe to the
//  pixel mux. Two instances (left and right player) sit under the top-level game
//  module.
// PARAMETERS
//  PADDLE_LEFT      10   fixed x of paddle left edge (pixels)
//  PADDLE_TOP_INIT  10   y of paddle top edge after reset
//  PADDLE_W         50   paddle width (pixels)
//  PADDLE_H         150  paddle height (pixels)
//  SCREEN_W         800  visible width
//  SCREEN_H         600  visible height; YMAX = SCREEN_H-PADDLE_H (450 default)
//  MAX_SPEED        4    speed ceiling (pixels/frame), >=1
//  ACCEL_FRAMES     8    frames moved at a given speed before speed+1, >=1
//  AI_DEADBAND      8    half-width of AI no-move window (pixels); used only with PADDLE_AI_EN
// PORTS
//  pixelClock    in   1   pixel clock; the only clock
//  Reset         in   1   synchronous, active-high reset
//  frameTick     in   1   one-cycle pulse per frame (start of vertical blank)
//  upPaddle      in   1   player up request (level)
//  downPaddle    in   1   player down request (level)
//  aiMode        in   1   1 = computer-controlled (see CONFIGURATION)
//  ballY         in   10  ball centre y, for AI tracking
//  xPosition     in   11  current scan x
//  yPosition     in   10  current scan y
//  topPaddle     out  11  paddle top edge y
//  bottomPaddle  out  11  topPaddle + PADDLE_H
//  leftPaddle    out  11  PADDLE_LEFT (constant)
//  rightPaddle   out  11  PADDLE_LEFT + PADDLE_W
//  atTop         out  1   topPaddle == 0
//  atBottom      out  1   topPaddle == YMAX
//  drawPaddle    out  1   scan position is inside the paddle
// BEHAVIOUR
//  - Reset (any cycle, including mid-movement) forces: top=PADDLE_TOP_INIT,
//    state=IDLE, speed=1, cnt=0, drawPaddle=0. Box, atTop and atBottom take
//    their values from PADDLE_TOP_INIT on the next cycle. Reset has priority
//    over frameTick.
//  - Position changes only on a frameTick cycle. The box outputs are registered
//    and show the new top in the cycle after frameTick. Between ticks the
//    position is held.
//  - dir is sampled in the frameTick cycle:
//    - up&~down -> UP; down&~up -> DOWN; both or neither -> NONE.
//  - State machine {IDLE, MOVE_UP, MOVE_DOWN}, evaluated on frameTick:
//    - dir NONE: go to IDLE, speed=1, cnt=0, no move.
//    - dir differs from current state (entry from IDLE or a reversal): load
//      speed=1, cnt=0, enter MOVE_x, then apply the move step.
//    - dir same as current state: apply the move step.
//  - Move step:
//    - DOWN: top = min(top+speed, YMAX).
//    - UP: top = (top<speed) ? 0 : top-speed.
//    - Then, if cnt==ACCEL_FRAMES-1: cnt=0 and speed=min(speed+1, MAX_SPEED);
//      else cnt++.
//  - Arithmetic is 11-bit unsigned. A clamp at an edge does not reset speed;
//    holding against the wall keeps top at 0 or YMAX.
//  - drawPaddle is registered with 1-cycle latency:
//    - 1 when leftPaddle<=xPosition<rightPaddle and topPaddle<=yPosition<bottomPaddle,
//      using the registered box.
// CONFIGURATION
//  - PADDLE_AI_EN defined:
//    - When aiMode=1, manual inputs are ignored and dir is derived from the
//      paddle centre c = top + PADDLE_H/2.
//    - ballY < c-AI_DEADBAND -> UP; ballY > c+AI_DEADBAND -> DOWN; else NONE.
//    - The same FSM, acceleration and clamping apply.
//  - PADDLE_AI_EN undefined: aiMode and ballY are ignored, AI_DEADBAND is
//    unused, and only manual control exists.
// TESTING
//  1. Reset, then idle: top=10, bottom=160, left=10, right=60, atTop=0,
//     atBottom=0, drawPaddle=0.
//  2. Hold down for 16 ticks from top=10: top=18 after tick 8 (speed->2),
//     top=34 after tick 16.
//  3. Hold down from top=440 with speed 4: top clamps at 450, atBottom=1,
//     further ticks keep 450. Hold up from top=3 with speed 4: top=0, atTop=1.
//  4. Reversal: speed 3 going down, then up only: next tick moves -1
//     (speed=1). Up+down together: no move, FSM returns to IDLE.
//  5. Assert Reset mid-ramp at speed 4, top=200: next cycle top=10. The first
//     tick afterwards moves 1 pixel.
//  6. Scan x=10,y=10 -> drawPaddle=1 one cycle later; x=60 -> 0; y=160 -> 0.
//     With PADDLE_AI_EN, aiMode=1, ballY=400, top=10: moves down.
//     With ballY=85 (centre): no move.

Source files
------------

// File: rtl/paddle_ctrl_if.sv
// Paddle engine bundle: frame/control/scan inputs and bounding-box outputs.
// master drives controls and scan position, slave is the paddle engine.
interface paddle_ctrl_if;
    logic        frameTick;
    logic        upPaddle;
    logic        downPaddle;
    logic        aiMode;
    logic [9:0]  ballY;
    logic [10:0] xPosition;
    logic [9:0]  yPosition;
    logic [10:0] topPaddle;
    logic [10:0] bottomPaddle;
    logic [10:0] leftPaddle;
    logic [10:0] rightPaddle;
    logic        atTop;
    logic        atBottom;
    logic        drawPaddle;

    modport master (
        output frameTick, upPaddle, downPaddle, aiMode, ballY,
        output xPosition, yPosition,
        input  topPaddle, bottomPaddle, leftPaddle, rightPaddle,
        input  atTop, atBottom, drawPaddle
    );

    modport slave (
        input  frameTick, upPaddle, downPaddle, aiMode, ballY,
        input  xPosition, yPosition,
        output topPaddle, bottomPaddle, leftPaddle, rightPaddle,
        output atTop, atBottom, drawPaddle
    );
endinterface

// File: rtl/paddle_ctrl.sv
// One paddle: per-frame movement with speed ramp and edge clamping.
// Optional computer tracking of the ball when PADDLE_AI_EN is defined.
module paddle_ctrl #(
    parameter int PADDLE_LEFT     = 10,
    parameter int PADDLE_TOP_INIT = 10,
    parameter int PADDLE_W        = 50,
    parameter int PADDLE_H        = 150,
    parameter int SCREEN_W        = 800,
    parameter int SCREEN_H        = 600,
    parameter int MAX_SPEED       = 4,
    parameter int ACCEL_FRAMES    = 8,
    parameter int AI_DEADBAND     = 8
) (
    input logic          pixelClock,
    input logic          Reset,
    paddle_ctrl_if.slave pif
);
    localparam logic [10:0] YMAX     = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] TOP_INIT = 11'(PADDLE_TOP_INIT);
    localparam logic [10:0] HEIGHT   = 11'(PADDLE_H);
    localparam logic [10:0] LEFT     = 11'(PADDLE_LEFT);
    localparam logic [10:0] RIGHT    = 11'(PADDLE_LEFT + PADDLE_W);
    localparam logic [10:0] SPD_MAX  = 11'(MAX_SPEED);
    localparam logic [15:0] ACC_LAST = 16'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

    state_t      state;
    dir_t        dir;
    logic [10:0] top;
    logic [10:0] speed;
    logic [15:0] cnt;
    logic [10:0] bottom;
    logic        atTopR;
    logic        atBottomR;
    logic        drawR;

    logic        entering;
    logic [10:0] spd;
    logic [15:0] cntCur;
    logic [10:0] sum;
    logic [10:0] topStep;
    logic [10:0] topNext;
    logic [10:0] spdNext;
    logic [15:0] cntNext;

`ifdef PADDLE_AI_EN
    localparam logic [11:0] DB = 12'(AI_DEADBAND);
    logic [11:0] centre;
    logic [11:0] ballW;
    assign centre = {1'b0, top} + 12'(PADDLE_H / 2);
    assign ballW  = {2'b00, pif.ballY};
`else
    logic unusedAi;
    assign unusedAi = ^{pif.aiMode, pif.ballY, 32'(AI_DEADBAND), 32'(SCREEN_W)};
`endif

    // Requested direction for this frame (manual levels or ball tracking)
    always_comb begin
        dir = DIR_NONE;
        if (pif.upPaddle && !pif.downPaddle)
            dir = DIR_UP;
        else if (pif.downPaddle && !pif.upPaddle)
            dir = DIR_DOWN;
`ifdef PADDLE_AI_EN
        if (pif.aiMode) begin
            dir = DIR_NONE;
            if (ballW + DB < centre)
                dir = DIR_UP;
            else if (ballW > centre + DB)
                dir = DIR_DOWN;
        end
`endif
    end

    // Move step, speed ramp and next position
    always_comb begin
        entering = (dir == DIR_UP && state != MOVE_UP) ||
                   (dir == DIR_DOWN && state != MOVE_DOWN);
        spd      = entering ? 11'd1 : speed;
        cntCur   = entering ? 16'd0 : cnt;
        sum      = top + spd;
        topStep  = top;
        unique case (dir)
            DIR_DOWN: topStep = (sum > YMAX) ? YMAX : sum;
            DIR_UP:   topStep = (top < spd) ? 11'd0 : top - spd;
            default:  topStep = top;
        endcase
        if (cntCur == ACC_LAST) begin
            cntNext = 16'd0;
            spdNext = (spd >= SPD_MAX) ? SPD_MAX : spd + 11'd1;
        end else begin
            cntNext = cntCur + 16'd1;
            spdNext = spd;
        end
        topNext = pif.frameTick ? topStep : top;
    end

    // Movement FSM, advanced once per frame
    always_ff @(posedge pixelClock) begin
        if (Reset) begin
            state <= IDLE;
            top   <= TOP_INIT;
            speed <= 11'd1;
            cnt   <= 16'd0;
        end else if (pif.frameTick) begin
            top <= topStep;
            unique case (dir)
                DIR_UP: begin
                    state <= MOVE_UP;
                    speed <= spdNext;
                    cnt   <= cntNext;
                end
                DIR_DOWN: begin
                    state <= MOVE_DOWN;
                    speed <= spdNext;
                    cnt   <= cntNext;
                end
                default: begin
                    state <= IDLE;
                    speed <= 11'd1;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    // Registered box edge and wall flags follow the next top
    always_ff @(posedge pixelClock) begin
        if (Reset) begin
            bottom    <= TOP_INIT + HEIGHT;
            atTopR    <= (TOP_INIT == 11'd0);
            atBottomR <= (TOP_INIT == YMAX);
        end else begin
            bottom    <= topNext + HEIGHT;
            atTopR    <= (topNext == 11'd0);
            atBottomR <= (topNext == YMAX);
        end
    end

    // Draw strobe from the registered box, one cycle behind the scan
    always_ff @(posedge pixelClock) begin
        if (Reset)
            drawR <= 1'b0;
        else
            drawR <= (pif.xPosition >= LEFT) &&
                     (pif.xPosition < RIGHT) &&
                     ({1'b0, pif.yPosition} >= top) &&
                     ({1'b0, pif.yPosition} < bottom);
    end

    assign pif.topPaddle    = top;
    assign pif.bottomPaddle = bottom;
    assign pif.leftPaddle   = LEFT;
    assign pif.rightPaddle  = RIGHT;
    assign pif.atTop        = atTopR;
    assign pif.atBottom     = atBottomR;
    assign pif.drawPaddle   = drawR;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: vector tables, corner sequences and a
// randomized run against a frame-level model of the paddle.
module tb_paddle_ctrl;
    localparam int YMAX = 450;

    logic pixelClock = 1'b0;
    logic Reset;
    always #5 pixelClock = ~pixelClock;

    paddle_ctrl_if pif ();

    paddle_ctrl dut (
        .pixelClock (pixelClock),
        .Reset      (Reset),
        .pif        (pif.slave)
    );

    typedef struct {
        bit up;
        bit down;
        int expTop;
    } mv_t;

    typedef struct {
        int x;
        int y;
        bit expDraw;
    } dv_t;

    int nRun  = 0;
    int nFail = 0;

    // model: position, speed, frames moved at that speed, heading
    int mTop;
    int mSpeed;
    int mCnt;
    int mHead;

    task automatic chk(input string name, input int got, input int exp);
        nRun++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge pixelClock);
        #1;
    endtask

    task automatic mReset();
        mTop   = 10;
        mSpeed = 1;
        mCnt   = 0;
        mHead  = 0;
    endtask

    // heading: -1 up, +1 down, 0 none
    task automatic mStep(input bit up, input bit down);
        int h;
        h = int'(down) - int'(up);
        if (h == 0) begin
            mHead  = 0;
            mSpeed = 1;
            mCnt   = 0;
        end else begin
            if (h != mHead) begin
                mHead  = h;
                mSpeed = 1;
                mCnt   = 0;
            end
            mTop = mTop + h * mSpeed;
            if (mTop < 0) mTop = 0;
            if (mTop > YMAX) mTop = YMAX;
            mCnt++;
            if (mCnt == 8) begin
                mCnt = 0;
                if (mSpeed < 4) mSpeed++;
            end
        end
    endtask

    task automatic pulse();
        pif.frameTick = 1'b1;
        clk1();
        pif.frameTick = 1'b0;
    endtask

    task automatic tick(input bit up, input bit down);
        pif.upPaddle   = up;
        pif.downPaddle = down;
        pulse();
        mStep(up, down);
    endtask

    task automatic chkBox(input string n);
        chk({n, ".top"}, int'(pif.topPaddle), mTop);
        chk({n, ".bottom"}, int'(pif.bottomPaddle), mTop + 150);
        chk({n, ".atTop"}, int'(pif.atTop), int'(mTop == 0));
        chk({n, ".atBottom"}, int'(pif.atBottom), int'(mTop == YMAX));
    endtask

    task automatic doReset();
        Reset = 1'b1;
        clk1();
        Reset = 1'b0;
        mReset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mv_t mv[$];
        dv_t dv[$];
        int run;
        bit ru;
        bit rd;

        // 8 frames at 1 px, 8 at 2 px, then reversal and cancel cases
        for (int i = 1; i <= 8; i++) mv.push_back('{0, 1, 10 + i});
        for (int i = 1; i <= 8; i++) mv.push_back('{0, 1, 18 + 2 * i});
        mv.push_back('{1, 0, 33});
        mv.push_back('{1, 1, 33});
        mv.push_back('{1, 0, 32});
        mv.push_back('{0, 1, 33});
        mv.push_back('{0, 0, 33});

        dv.push_back('{10, 10, 1});
        dv.push_back('{60, 10, 0});
        dv.push_back('{59, 159, 1});
        dv.push_back('{10, 160, 0});
        dv.push_back('{9, 50, 0});
        dv.push_back('{30, 9, 0});
        dv.push_back('{35, 80, 1});

        pif.frameTick  = 1'b0;
        pif.upPaddle   = 1'b0;
        pif.downPaddle = 1'b0;
        pif.aiMode     = 1'b0;
        pif.ballY      = '0;
        pif.xPosition  = '0;
        pif.yPosition  = '0;
        Reset          = 1'b1;
        clk1();
        clk1();
        Reset = 1'b0;
        mReset();

        chkBox("reset");
        chk("reset.left", int'(pif.leftPaddle), 10);
        chk("reset.right", int'(pif.rightPaddle), 60);
        chk("reset.draw", int'(pif.drawPaddle), 0);
        repeat (3) clk1();
        chkBox("idle");

        foreach (dv[i]) begin
            pif.xPosition = 11'(dv[i].x);
            pif.yPosition = 10'(dv[i].y);
            clk1();
            chk($sformatf("draw[%0d]", i), int'(pif.drawPaddle),
                int'(dv[i].expDraw));
        end
        pif.xPosition = '0;
        pif.yPosition = '0;

        foreach (mv[i]) begin
            tick(mv[i].up, mv[i].down);
            chk($sformatf("move[%0d]", i), int'(pif.topPaddle),
                mv[i].expTop);
            chkBox("move.model");
        end

        // levels without a frame tick never move the paddle
        pif.upPaddle = 1'b1;
        repeat (5) clk1();
        chk("hold.top", int'(pif.topPaddle), 33);
        pif.upPaddle = 1'b0;

        // bottom and top clamps with speed saturated
        doReset();
        repeat (150) begin
            tick(0, 1);
            chkBox("clampDn");
        end
        chk("clampDn.top", int'(pif.topPaddle), 450);
        chk("clampDn.atBottom", int'(pif.atBottom), 1);
        repeat (150) begin
            tick(1, 0);
            chkBox("clampUp");
        end
        chk("clampUp.top", int'(pif.topPaddle), 0);
        chk("clampUp.atTop", int'(pif.atTop), 1);

        // reset mid-ramp wins over a coincident frame tick
        doReset();
        repeat (40) tick(0, 1);
        pif.downPaddle = 1'b1;
        pif.frameTick  = 1'b1;
        Reset          = 1'b1;
        clk1();
        pif.frameTick = 1'b0;
        Reset         = 1'b0;
        mReset();
        chk("midReset.top", int'(pif.topPaddle), 10);
        clk1();
        chkBox("midReset");
        tick(0, 1);
        chk("midReset.step", int'(pif.topPaddle), 11);

`ifdef PADDLE_AI_EN
        doReset();
        pif.aiMode = 1'b1;
        pif.ballY  = 10'd400;
        pulse();
        chk("ai.down", int'(pif.topPaddle), 11);
        doReset();
        pif.ballY    = 10'd85;
        pif.upPaddle = 1'b1;
        pulse();
        chk("ai.centre", int'(pif.topPaddle), 10);
        pif.upPaddle = 1'b0;
        pif.aiMode   = 1'b0;
        doReset();
`else
        doReset();
        pif.aiMode = 1'b1;
        pif.ballY  = 10'd0;
        tick(0, 1);
        chk("noAi.manual", int'(pif.topPaddle), 11);
        pif.aiMode = 1'b0;
        doReset();
`endif

        // randomized runs of held inputs with idle gaps between frames
        run = 0;
        ru  = 0;
        rd  = 0;
        repeat (500) begin
            if (run == 0) begin
                run = int'($urandom_range(1, 40));
                ru  = 1'($urandom);
                rd  = 1'($urandom);
            end
            run--;
            pif.upPaddle   = 1'($urandom);
            pif.downPaddle = 1'($urandom);
            repeat ($urandom_range(0, 2)) clk1();
            tick(ru, rd);
            chkBox("rand");
        end

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end
endmodule
